ddr2_write_sequencer_0: RTL and testbench

DDR2_WRITE_SEQUENCER_0 -- requirements
Module: DDR2_write_sequencer_0

---
 rtl/ddr2_write_sequencer_0.sv | 121 ++++++++++++
 tb/tb_ddr2_write_sequencer_0.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_write_sequencer_0.sv
// Purpose : DDR2 write-burst scheduler that drives FIFO read, DQS and data-enable strobes.
// Latency : the FIFO read starts WRITE_LATENCY-1 cycles after an accepted wr_cmd; data starts WRITE_LATENCY cycles after it.
// Backpr. : wr_ready drops for B-1 cycles after each accept; a wr_cmd while not ready is dropped and flagged.
//
// Ports:
//   clk, reset_n        - single clock, synchronous active-low reset
//   wr_cmd, burst_len   - write command pulse and burst length (0 = BL4, 1 = BL8)
//   wdf_empty           - write data FIFO empty flag
//   wr_ready            - the next wr_cmd will be accepted
//   ctrl_wren           - data-cycle enable to the write datapath
//   ctrl_dqs_rst        - DQS preamble reset
//   ctrl_dqs_en         - DQS drive enable
//   wdf_rden            - write data FIFO read enable (FIFO has 1-cycle read latency)
//   wr_active           - some accepted burst has not yet finished its postamble
//   err_overrun         - sticky: wr_cmd arrived while wr_ready was low
//   err_underrun        - sticky: the FIFO was read while it was empty
module ddr2_write_sequencer_0 #(
    parameter int WRITE_LATENCY = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wr_cmd,
    input  logic burst_len,
    input  logic wdf_empty,
    output logic wr_ready,
    output logic ctrl_wren,
    output logic ctrl_dqs_rst,
    output logic ctrl_dqs_en,
    output logic wdf_rden,
    output logic wr_active,
    output logic err_overrun,
    output logic err_underrun
);

    localparam int W = WRITE_LATENCY;
    // Long enough to hold the full footprint of a BL8 burst, postamble included.
    localparam int L = W + 4;

    if (WRITE_LATENCY < 2 || WRITE_LATENCY > 7) begin : g_bad_latency
        $error("WRITE_LATENCY must be in 2..7");
    end

    // Bit i of a schedule register set means "assert this output i cycles after
    // the next clock edge"; bit 0 is therefore the registered output itself.
    function automatic logic [L-1:0] span(input int lo, input int hi);
        logic [L-1:0] m;
        m = '0;
        for (int i = 0; i < L; i++) begin
            if (i >= lo && i <= hi) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Masks are placed relative to the accept cycle N; bit 0 lands on N+1.
    localparam logic [L-1:0] RDEN_BL4 = span(W - 2, W - 1);
    localparam logic [L-1:0] RDEN_BL8 = span(W - 2, W + 1);
    localparam logic [L-1:0] WREN_BL4 = span(W - 1, W);
    localparam logic [L-1:0] WREN_BL8 = span(W - 1, W + 2);
    localparam logic [L-1:0] EN_BL4   = span(W - 2, W);
    localparam logic [L-1:0] EN_BL8   = span(W - 2, W + 2);
    localparam logic [L-1:0] ACT_BL4  = span(0, W + 1);
    localparam logic [L-1:0] ACT_BL8  = span(0, W + 3);

    logic [L-1:0] rden_sr, wren_sr, en_sr, act_sr;
    logic [L-1:0] rden_nxt, wren_nxt, en_nxt, act_nxt;
    logic [1:0]   spc, spc_nxt;
    logic         accept;
    logic         dqs_rst_q;

    always_comb begin
        accept   = wr_cmd & wr_ready;
        rden_nxt = {1'b0, rden_sr[L-1:1]};
        wren_nxt = {1'b0, wren_sr[L-1:1]};
        en_nxt   = {1'b0, en_sr[L-1:1]};
        act_nxt  = {1'b0, act_sr[L-1:1]};
        spc_nxt  = (spc != 2'd0) ? spc - 2'd1 : 2'd0;
        if (accept) begin
            // Overlapping bursts simply OR into the running schedule.
            rden_nxt = rden_nxt | (burst_len ? RDEN_BL8 : RDEN_BL4);
            wren_nxt = wren_nxt | (burst_len ? WREN_BL8 : WREN_BL4);
            en_nxt   = en_nxt   | (burst_len ? EN_BL8   : EN_BL4);
            act_nxt  = act_nxt  | (burst_len ? ACT_BL8  : ACT_BL4);
            spc_nxt  = burst_len ? 2'd3 : 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rden_sr      <= '0;
            wren_sr      <= '0;
            en_sr        <= '0;
            act_sr       <= '0;
            spc          <= 2'd0;
            wr_ready     <= 1'b1;
            dqs_rst_q    <= 1'b0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            rden_sr      <= rden_nxt;
            wren_sr      <= wren_nxt;
            en_sr        <= en_nxt;
            act_sr       <= act_nxt;
            spc          <= spc_nxt;
            wr_ready     <= (spc_nxt == 2'd0);
            // A preamble is only needed when DQS turns on from idle; a burst
            // that chains onto one still driving DQS gets none.
            dqs_rst_q    <= en_nxt[0] & ~en_sr[0];
            err_overrun  <= err_overrun | (wr_cmd & ~wr_ready);
            err_underrun <= err_underrun | (wdf_rden & wdf_empty);
        end
    end

    assign wdf_rden     = rden_sr[0];
    assign ctrl_wren    = wren_sr[0];
    assign ctrl_dqs_en  = en_sr[0];
    assign wr_active    = act_sr[0];
    assign ctrl_dqs_rst = dqs_rst_q;

endmodule

// File: tb/tb_ddr2_write_sequencer_0.sv
module tb_ddr2_write_sequencer_0;

    localparam int W    = 3;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic wr_cmd = 1'b0;
    logic burst_len = 1'b0;
    logic wdf_empty = 1'b0;
    logic wr_ready, ctrl_wren, ctrl_dqs_rst, ctrl_dqs_en, wdf_rden;
    logic wr_active, err_overrun, err_underrun;

    always #5 clk = ~clk;

    ddr2_write_sequencer_0 #(.WRITE_LATENCY(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_cmd       (wr_cmd),
        .burst_len    (burst_len),
        .wdf_empty    (wdf_empty),
        .wr_ready     (wr_ready),
        .ctrl_wren    (ctrl_wren),
        .ctrl_dqs_rst (ctrl_dqs_rst),
        .ctrl_dqs_en  (ctrl_dqs_en),
        .wdf_rden     (wdf_rden),
        .wr_active    (wr_active),
        .err_overrun  (err_overrun),
        .err_underrun (err_underrun)
    );

    typedef struct packed {
        logic wren;
        logic en;
        logic rst;
        logic rden;
        logic ready;
        logic active;
        logic ovr;
        logic und;
    } exp_t;

    exp_t exp_q[$];

    // Reference schedule, indexed by absolute cycle number.
    bit e_wren [0:MAXC-1];
    bit e_en   [0:MAXC-1];
    bit e_rden [0:MAXC-1];
    bit e_pre  [0:MAXC-1];

    int  c = 0;
    int  checks = 0;
    int  passed = 0;
    int  fails = 0;
    int  last_acc = -1000;
    int  last_b = 2;
    bit  ovr = 1'b0;
    bit  und = 1'b0;
    bit  cur_ready = 1'b1;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, expv);
        end
    endtask

    // One cycle: check the outputs of the current cycle, drive this cycle's
    // inputs, predict the next cycle's outputs, advance the clock.
    task automatic step(input bit cmd, input bit bl, input bit empty, input bit rstn);
        exp_t e, n;
        int   b;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctrl_wren",    ctrl_wren,    e.wren);
            check("ctrl_dqs_en",  ctrl_dqs_en,  e.en);
            check("ctrl_dqs_rst", ctrl_dqs_rst, e.rst);
            check("wdf_rden",     wdf_rden,     e.rden);
            check("wr_ready",     wr_ready,     e.ready);
            check("wr_active",    wr_active,    e.active);
            check("err_overrun",  err_overrun,  e.ovr);
            check("err_underrun", err_underrun, e.und);
        end
        wr_cmd    = cmd;
        burst_len = bl;
        wdf_empty = empty;
        reset_n   = rstn;
        n = '0;
        if (!rstn) begin
            for (int k = c + 1; k < MAXC; k++) begin
                e_wren[k] = 1'b0;
                e_en[k]   = 1'b0;
                e_rden[k] = 1'b0;
                e_pre[k]  = 1'b0;
            end
            last_acc = -1000;
            last_b   = 2;
            ovr      = 1'b0;
            und      = 1'b0;
            n.ready  = 1'b1;
        end else begin
            if (cmd && !cur_ready) ovr = 1'b1;
            if (e_rden[c] && empty) und = 1'b1;
            if (cmd && cur_ready) begin
                b        = bl ? 4 : 2;
                last_acc = c;
                last_b   = b;
                for (int k = c + W - 1; k <= c + W + b - 2; k++) e_rden[k] = 1'b1;
                for (int k = c + W;     k <= c + W + b - 1; k++) e_wren[k] = 1'b1;
                for (int k = c + W - 1; k <= c + W + b - 1; k++) e_en[k]   = 1'b1;
                e_pre[c + W - 1] = 1'b1;
            end
            n.wren   = e_wren[c + 1];
            n.en     = e_en[c + 1];
            n.rden   = e_rden[c + 1];
            n.rst    = e_pre[c + 1] && !e_en[c];
            n.ready  = (c + 1 >= last_acc + last_b);
            n.active = (c + 1 >= last_acc + 1) && (c + 1 <= last_acc + W + last_b);
            n.ovr    = ovr;
            n.und    = und;
        end
        cur_ready = n.ready;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // Single BL4
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // BL8 then BL8 four cycles later: contiguous data
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(10);

        // BL4 then BL4 three cycles later: DQS stays on through the gap
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // BL4 back-to-back at minimum spacing
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // burst_len toggles while a BL8 is in flight, then a BL4 follows
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // Underrun: FIFO empty while the first read is scheduled
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);

        // Overrun: second command while not ready is dropped
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(8);
        do_reset();

        // Reset in the middle of a BL8
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        // Command held during reset is ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
        end
        idle(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
